// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 one-wire output stage.
package ws2812_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, BIT, LATCH} state_t;

  localparam int DEF_NUM_LEDS = 7;
  localparam int DEF_T_BIT    = 13;
  localparam int DEF_T0H      = 4;
  localparam int DEF_T1H      = 8;
  localparam int DEF_T_LATCH  = 3000;
  localparam int BYTES_PER_LED = 3;

endpackage

// File: rtl/ws2812_gamma.sv
// 8-bit gamma approximation g = (b*b)>>8; only exists when WS2812_GAMMA_EN is defined.
`ifdef WS2812_GAMMA_EN
module ws2812_gamma (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  logic [15:0] sq;

  assign sq     = {8'd0, byte_i} * {8'd0, byte_i};
  assign byte_o = 8'(sq >> 8);

endmodule
`endif

// File: rtl/ws2812_out.sv
// WS2812 NRZ serialiser: snapshots a GRB image per frame, sends it MSB-first, then latches.
// Optional gamma correction of every byte at load time with `define WS2812_GAMMA_EN.
module ws2812_out
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_LATCH  = DEF_T_LATCH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [24*NUM_LEDS-1:0]    data_in,
  input  logic                      enable,
  output logic                      dout,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int NB      = BYTES_PER_LED * NUM_LEDS;
  localparam int DW      = 8 * NB;
  localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BYTE_W  = $clog2(NB + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              bit_q, bit_d;
  logic [BYTE_W-1:0]       byte_q, byte_d;
  logic [7:0]              shift_q, shift_d;
  logic [NB-1:0][7:0]      snap_q, snap_d;

  logic [BYTE_W-1:0]       byte_nxt;
  logic [BYTE_W-1:0]       ridx;
  logic [7:0]              raw_byte;
  logic [7:0]              load_byte;
  logic [CNT_W-1:0]        thr;

  // byte(k) lives in packed element NB-1-k; the clamp only matters past the last byte.
  assign byte_nxt = byte_q + 1'b1;
  assign ridx     = (byte_nxt < BYTE_W'(NB)) ? (BYTE_W'(NB - 1) - byte_nxt) : '0;
  assign raw_byte = (state_q == LOAD) ? data_in[DW-1 -: 8] : snap_q[ridx];

`ifdef WS2812_GAMMA_EN
  ws2812_gamma u_gamma (
    .byte_i (raw_byte),
    .byte_o (load_byte)
  );
`else
  assign load_byte = raw_byte;
`endif

  assign thr        = shift_q[bit_q] ? CNT_W'(T1H) : CNT_W'(T0H);
  assign dout       = (state_q == BIT) && (cnt_q < thr);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == LATCH) && (cnt_q == CNT_W'(T_LATCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LATCH;
      cnt_q   <= '0;
      bit_q   <= 3'd7;
      byte_q  <= '0;
      shift_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    snap_d  = snap_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = LOAD;
      end

      LOAD: begin
        snap_d  = data_in;
        byte_d  = '0;
        bit_d   = 3'd7;
        shift_d = load_byte;
        cnt_d   = '0;
        state_d = BIT;
      end

      BIT: begin
        if (cnt_q == CNT_W'(T_BIT - 1)) begin
          cnt_d = '0;
          if (bit_q == 3'd0) begin
            if (byte_q == BYTE_W'(NB - 1)) begin
              state_d = LATCH;
            end else begin
              byte_d  = byte_nxt;
              bit_d   = 3'd7;
              shift_d = load_byte;
            end
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LATCH: begin
        if (cnt_q == CNT_W'(T_LATCH - 1)) begin
          cnt_d   = '0;
          state_d = enable ? LOAD : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = LATCH;
    endcase
  end

endmodule

// File: doc/ws2812_out.md
Name: ws2812_out

Overview:
- Downstream stage of the APA102 SPI receiver: takes its 168-bit 7-LED GRB image and re-emits it as a WS2812 one-wire NRZ pulse stream on a single output pin.
- Free-running refresh. Each frame snapshots data_in, serialises 7×24 bits MSB-first (LED0 = data_in[167:144], G,R,B byte order), then holds the line low for the latch interval.

Parameters:
- NUM_LEDS, 7, LEDs per frame; data_in width = 24*NUM_LEDS.
- T_BIT, 13, clk cycles per bit (1.3 us at 10 MHz).
- T0H, 4, high cycles for a '0' bit.
- T1H, 8, high cycles for a '1' bit.
- T_LATCH, 3000, low cycles of reset/latch gap (300 us at 10 MHz).
- Legal range: 0 < T0H < T1H < T_BIT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  24*NUM_LEDS  GRB image from upstream; sampled only at frame load.
- enable  in  1  1 = keep refreshing; 0 = finish current frame and latch, then idle.
- dout  out  1  WS2812 data line.
- busy  out  1  high from LOAD through the end of LATCH.
- frame_done  out  1  one-cycle pulse on the last LATCH cycle.

Behaviour:
- Reset (async assert, synchronous deassert use): state=LATCH, cycle counter=0, dout=0, busy=1, frame_done=0, snapshot=0.
- The first LATCH after reset runs a full T_LATCH cycles, which guarantees a clean latch before the first frame.
- States and transitions:
  - IDLE: dout=0, busy=0. Goes to LOAD when enable=1.
  - LOAD: 1 cycle. snapshot<=data_in; byte_idx=0; bit_idx=7; shift_byte<=byte(0). dout=0.
  - BIT: cycle counter c counts 0..T_BIT-1. dout = (c < (cur_bit ? T1H : T0H)).
    - At c=T_BIT-1, advance: bit_idx--. At bit 0, byte_idx++ and reload shift_byte.
    - After the last bit of byte 3*NUM_LEDS-1, go to LATCH.
  - LATCH: dout=0 for T_LATCH cycles. On the last cycle, pulse frame_done, then go to LOAD if enable=1, else IDLE.
- Byte selection: byte(k) = snapshot[24*NUM_LEDS-1-8k -: 8].
- First rising edge of dout occurs the cycle after LOAD.
- Frame length = 1 + 24*NUM_LEDS*T_BIT + T_LATCH cycles = 5185 at defaults.
- data_in changes mid-frame have no effect until the next LOAD.
- enable deasserting mid-frame never truncates a bit or the frame. Reasserting during LATCH continues without passing through IDLE.
- rst_n asserted mid-bit: dout drops to 0 immediately (async), and the frame is abandoned.
- Counters are sized by $clog2 of their maximum values; no wrap occurs within legal parameters.

Optional Feature:
- Macro WS2812_GAMMA_EN.
- Defined: each byte is gamma-corrected at byte load as g = (b*b)>>8, using one shared 8×8 multiplier. Endpoints: 0→0, 255→254, 128→64. Timing is unchanged.
- Undefined: bytes are sent verbatim and no multiplier is instantiated.

Decomposition:
- Package ws2812_pkg: state enum (IDLE, LOAD, BIT, LATCH), default timing constants, BYTES_PER_LED=3.
- Sub-module ws2812_gamma: 8-bit combinational squarer/shift, instantiated only under WS2812_GAMMA_EN.

Test Plan:
- Reset, enable=1, data_in=0: dout low 3000 cycles, then 168 pulses each high exactly 4 cycles within a 13-cycle period; frame_done pulses at cycle 5185 after the first LOAD.
- data_in[167:144]=24'h800001, remainder 0: bit 0 of the frame is high 8 cycles, bits 1..22 high 4 cycles, bit 23 high 8 cycles; bits 24..167 high 4 cycles.
- data_in changed from 168'h0 to all-ones midway through bit 50: the current frame stays all '0' pulses; the next frame is all 8-cycle highs.
- enable dropped during bit 10: the frame completes all 168 bits plus LATCH, frame_done pulses, then IDLE with busy=0 and dout=0. Re-enable -> LOAD on the next cycle.
- rst_n pulsed low during a high phase: dout=0 in the same cycle; after release, a full 3000-cycle LATCH precedes a fresh LOAD.
- With WS2812_GAMMA_EN defined, LED0 = G 8'hFF, R 8'h80, B 8'h10: transmitted bytes are 8'hFE, 8'h40, 8'h01.
